// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register-bank access port among N_REQ requesters.
// Define REG_ARB_LOCK_EN to let the owner hold the grant across accesses via req_lock.
module reg_access_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int REG_N      = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
  input  logic [N_REQ-1:0]               req_lock,
  output logic [N_REQ-1:0]               req_ready,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_WIDTH-1:0]          mem_wrAddr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [DATA_WIDTH/8-1:0]        mem_wrByteStrobe,
  output logic [ADDR_WIDTH-1:0]          mem_rdAddr,
  output logic                           mem_rdStrobe,
  input  logic [DATA_WIDTH-1:0]          mem_rddata,
  output logic                           busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        owner_reg, owner_next;
  logic                    we_reg, we_next;
  logic                    oor_reg, oor_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [STRB_W-1:0]       wr_strb_reg, wr_strb_next;
  logic                    rd_strobe_reg, rd_strobe_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic                    busy_reg, busy_next;
  logic [N_REQ-1:0]        rsp_valid_reg, rsp_valid_next;

  logic [ADDR_WIDTH-1:0]   addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [N_REQ];
  logic [STRB_W-1:0]       wstrb_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

`ifdef REG_ARB_LOCK_EN
  logic lock_reg, lock_next;
`else
  logic lock_unused;
  assign lock_unused = ^req_lock;
`endif

  logic             grant_found;
  logic             grant_locked;
  logic [PTR_W-1:0] grant_idx;
  logic             sel_oor;

  // First valid requester at or after ptr; a live lock overrides the rotation.
  always_comb begin : arbitrate
    logic [PTR_W:0] idx;
    idx          = '0;
    grant_found  = 1'b0;
    grant_locked = 1'b0;
    grant_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
      if (!grant_found && req_valid[idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
`ifdef REG_ARB_LOCK_EN
    if (lock_reg && req_valid[owner_reg]) begin
      grant_found  = 1'b1;
      grant_locked = 1'b1;
      grant_idx    = owner_reg;
    end
`endif
  end

  assign sel_oor = (32'(addr_arr[grant_idx]) >= REG_N);

  always_comb begin
    req_ready = '0;
    if (S_AXI_ARESETN && state_reg == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    we_next        = we_reg;
    oor_next       = oor_reg;
    cnt_next       = cnt_reg;
    wr_addr_next   = wr_addr_reg;
    rd_addr_next   = rd_addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    wr_strb_next   = '0;
    rd_strobe_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_valid_next = '0;
`ifdef REG_ARB_LOCK_EN
    lock_next      = lock_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef REG_ARB_LOCK_EN
        lock_next = lock_reg && req_valid[owner_reg];
`endif
        if (grant_found) begin
          state_next = ISSUE;
          owner_next = grant_idx;
          we_next    = req_we[grant_idx];
          oor_next   = sel_oor;
          if (!grant_locked)
            ptr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
          // Strobes are loaded here so they are visible during ISSUE.
          if (!sel_oor) begin
            if (req_we[grant_idx]) begin
              wr_addr_next = addr_arr[grant_idx];
              wdata_next   = wdata_arr[grant_idx];
              wr_strb_next = wstrb_arr[grant_idx];
            end else begin
              rd_addr_next   = addr_arr[grant_idx];
              rd_strobe_next = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_reg || oor_reg) begin
          state_next                = RESP;
          rsp_valid_next[owner_reg] = 1'b1;
          rsp_err_next              = oor_reg;
          rdata_next                = '0;
        end else begin
          state_next = RWAIT;
          cnt_next   = '0;
        end
      end
      RWAIT: begin
        if (cnt_reg == 3'(RD_LATENCY-1)) begin
          state_next                = RESP;
          rsp_valid_next[owner_reg] = 1'b1;
          rdata_next                = mem_rddata;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
`ifdef REG_ARB_LOCK_EN
        lock_next  = req_lock[owner_reg];
`endif
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      we_reg        <= 1'b0;
      oor_reg       <= 1'b0;
      cnt_reg       <= '0;
      wr_addr_reg   <= '0;
      rd_addr_reg   <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      wr_strb_reg   <= '0;
      rd_strobe_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_valid_reg <= '0;
      busy_reg      <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_reg      <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      we_reg        <= we_next;
      oor_reg       <= oor_next;
      cnt_reg       <= cnt_next;
      wr_addr_reg   <= wr_addr_next;
      rd_addr_reg   <= rd_addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      wr_strb_reg   <= wr_strb_next;
      rd_strobe_reg <= rd_strobe_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_valid_reg <= rsp_valid_next;
      busy_reg      <= busy_next;
`ifdef REG_ARB_LOCK_EN
      lock_reg      <= lock_next;
`endif
    end
  end

  assign rsp_valid        = rsp_valid_reg;
  assign rsp_rdata        = rdata_reg;
  assign rsp_err          = rsp_err_reg;
  assign mem_wrAddr       = wr_addr_reg;
  assign mem_wdata        = wdata_reg;
  assign mem_wrByteStrobe = wr_strb_reg;
  assign mem_rdAddr       = rd_addr_reg;
  assign mem_rdStrobe     = rd_strobe_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: two requesters, RD_LATENCY=2, behavioural register bank.
module tb_reg_access_arbiter;

  localparam int N_REQ = 2;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int SW    = DW / 8;
  localparam int RDL   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [N_REQ*AW-1:0]  req_addr;
  logic [N_REQ*DW-1:0]  req_wdata;
  logic [N_REQ*SW-1:0]  req_wstrb;
  logic [DW-1:0]        rsp_rdata, mem_wdata, mem_rddata;
  logic                 rsp_err, mem_rdStrobe, busy;
  logic [AW-1:0]        mem_wrAddr, mem_rdAddr;
  logic [SW-1:0]        mem_wrByteStrobe;

  int n_checks;
  int n_errors;
  logic [1:0] exp_order [4];

  always #5 clk = ~clk;

  reg_access_arbiter #(
    .N_REQ(N_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_N(6), .RD_LATENCY(RDL)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wrAddr(mem_wrAddr), .mem_wdata(mem_wdata), .mem_wrByteStrobe(mem_wrByteStrobe),
    .mem_rdAddr(mem_rdAddr), .mem_rdStrobe(mem_rdStrobe), .mem_rddata(mem_rddata),
    .busy(busy)
  );

  // Register bank model; reset reloads known contents (index 3 holds 32'h12345678).
  logic [DW-1:0] mem    [16];
  logic [DW-1:0] pipe_d [RDL];
  logic          pipe_v [RDL];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 32'h1234_5678 : (32'hA5A5_0000 | i);
      for (int s = 0; s < RDL; s++) begin
        pipe_v[s] <= 1'b0;
        pipe_d[s] <= '0;
      end
    end else begin
      for (int b = 0; b < SW; b++)
        if (mem_wrByteStrobe[b]) mem[mem_wrAddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      pipe_v[0] <= mem_rdStrobe;
      pipe_d[0] <= mem[mem_rdAddr];
      for (int s = 1; s < RDL; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_d[s] <= pipe_d[s-1];
      end
    end
  end

  // Garbage outside the valid data cycle exposes mis-timed sampling.
  assign mem_rddata = (pipe_v[RDL-1] === 1'b1) ? pipe_d[RDL-1] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = wd;
    req_wstrb[i*SW +: SW] = ws;
  endtask

  task automatic log_txn(input string what);
    $display("[%0t] txn %s", $time, what);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wstrb", mem_wrByteStrobe, 0);
    check("rst_rdstrobe", mem_rdStrobe, 0);
    check("rst_wraddr", mem_wrAddr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    req_valid = 2'b11;
    #1 check("rst_ready", req_ready, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single write by req0
    set_req(0, 1'b1, 4'd2, 32'hDEAD_BEEF, 4'hF);
    req_valid = 2'b01;
    #1 check("wr_ready", req_ready, 2'b01);
    log_txn("req0 write addr=2 data=deadbeef strb=f");
    tick();
    req_valid = '0;
    check("wr_strobe", mem_wrByteStrobe, 4'hF);
    check("wr_addr", mem_wrAddr, 2);
    check("wr_data", mem_wdata, 32'hDEAD_BEEF);
    check("wr_busy", busy, 1);
    check("wr_rsp_early", rsp_valid, 0);
    tick();
    check("wr_rsp", rsp_valid, 2'b01);
    check("wr_err", rsp_err, 0);
    check("wr_strobe_off", mem_wrByteStrobe, 0);
    tick();
    check("wr_rsp_once", rsp_valid, 0);
    check("wr_idle", busy, 0);

    // Read by req1 with two-cycle read latency
    set_req(1, 1'b0, 4'd3, 32'h0, 4'h0);
    req_valid = 2'b10;
    #1 check("rd_ready", req_ready, 2'b10);
    log_txn("req1 read addr=3");
    tick();
    req_valid = '0;
    check("rd_strobe", mem_rdStrobe, 1);
    check("rd_addr", mem_rdAddr, 3);
    tick();
    check("rd_strobe_off", mem_rdStrobe, 0);
    check("rd_rsp_t2", rsp_valid, 0);
    tick();
    check("rd_rsp_t3", rsp_valid, 0);
    tick();
    check("rd_rsp_t4", rsp_valid, 2'b10);
    check("rd_data", rsp_rdata, 32'h1234_5678);
    check("rd_err", rsp_err, 0);
    tick();
    check("rd_rsp_once", rsp_valid, 0);

    // Both requesters held valid: round-robin 0,1,0,1
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    set_req(0, 1'b1, 4'd4, 32'h1111_1111, 4'hF);
    set_req(1, 1'b1, 4'd5, 32'h2222_2222, 4'hF);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", req_ready, exp_order[k]);
      check("rr_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
      log_txn($sformatf("rr access %0d grant=%b", k, req_ready));
      tick();
      check("rr_ready_issue", req_ready, 0);
      tick();
      check("rr_ready_resp", req_ready, 0);
      check("rr_rsp", rsp_valid, exp_order[k]);
      tick();
    end
    req_valid = '0;

    // Out-of-range read by req0
    set_req(0, 1'b0, 4'd7, 32'h0, 4'h0);
    req_valid = 2'b01;
    #1 check("oor_ready", req_ready, 2'b01);
    log_txn("req0 read addr=7 (out of range)");
    tick();
    req_valid = '0;
    check("oor_rdstrobe", mem_rdStrobe, 0);
    check("oor_wrstrobe", mem_wrByteStrobe, 0);
    tick();
    check("oor_rsp", rsp_valid, 2'b01);
    check("oor_err", rsp_err, 1);
    check("oor_rdata", rsp_rdata, 0);
    tick();
    check("oor_rsp_once", rsp_valid, 0);
    check("oor_err_clear", rsp_err, 0);

    // Write with zero byte strobes by req1
    set_req(1, 1'b1, 4'd1, 32'hCAFE_F00D, 4'h0);
    req_valid = 2'b10;
    #1 check("ws0_ready", req_ready, 2'b10);
    log_txn("req1 write addr=1 strb=0");
    tick();
    req_valid = '0;
    check("ws0_strobe", mem_wrByteStrobe, 0);
    tick();
    check("ws0_rsp", rsp_valid, 2'b10);
    check("ws0_err", rsp_err, 0);
    tick();
    check("ws0_rsp_once", rsp_valid, 0);

    // Reset in the middle of a read; ptr was advanced to 1 by the accepted read
    set_req(0, 1'b0, 4'd3, 32'h0, 4'h0);
    req_valid = 2'b01;
    #1 check("rstrd_ready", req_ready, 2'b01);
    log_txn("req0 read addr=3 (aborted by reset)");
    tick();
    req_valid = '0;
    tick();
    check("rstrd_busy_rwait", busy, 1);
    rst_n = 1'b0;
    tick();
    check("rstrd_busy", busy, 0);
    check("rstrd_rsp", rsp_valid, 0);
    check("rstrd_rdaddr", mem_rdAddr, 0);
    tick();
    check("rstrd_rsp_late", rsp_valid, 0);
    set_req(0, 1'b1, 4'd4, 32'h55AA_55AA, 4'hF);
    set_req(1, 1'b1, 4'd5, 32'h66BB_66BB, 4'hF);
    req_valid = 2'b11;
    #1 check("rstrd_ready_in_rst", req_ready, 0);
    rst_n = 1'b1;
    #1 check("rstrd_ptr0", req_ready, 2'b01);
    log_txn("req0 write addr=4 after reset");
    tick();
    req_valid = '0;
    check("rstrd_wrstrobe", mem_wrByteStrobe, 4'hF);
    check("rstrd_wraddr", mem_wrAddr, 4);
    tick();
    check("rstrd_wr_rsp", rsp_valid, 2'b01);
    tick();

    // Lock held by req1 (ptr=1); req0 waiting throughout
`ifdef REG_ARB_LOCK_EN
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b10; exp_order[3] = 2'b01;
`else
    exp_order[0] = 2'b10; exp_order[1] = 2'b01; exp_order[2] = 2'b10; exp_order[3] = 2'b01;
`endif
    set_req(0, 1'b1, 4'd0, 32'hAAAA_0000, 4'hF);
    set_req(1, 1'b1, 4'd1, 32'hBBBB_1111, 4'hF);
    req_lock  = 2'b10;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("lock_grant", req_ready, exp_order[k]);
      log_txn($sformatf("lock access %0d grant=%b lock=%b", k, req_ready, req_lock));
      tick();
      if (k == 2) req_lock = '0;
      tick();
      check("lock_rsp", rsp_valid, exp_order[k]);
      tick();
    end
    req_valid = '0;
    req_lock  = '0;
    tick();
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
